// File: rtl/lvds_tx_serializer.sv
// lvds_tx_serializer: 7:1 LVDS transmit serializer running in the serial-bit clock domain.
// Optional feature: define LVDS_TX_PRBS_EN to add the prbs_en input and per-lane PRBS7 generators.
module lvds_tx_serializer #(
    parameter int         LANES       = 4,
    parameter logic [6:0] CLK_PATTERN = 7'b1100011,
    parameter bit         MSB_FIRST   = 1'b1
) (
    input  logic             Serial_Clock,
    input  logic             reset,
    input  logic             color_mode,
`ifdef LVDS_TX_PRBS_EN
    input  logic             prbs_en,
`endif
    input  logic             px_valid,
    output logic             px_ready,
    input  logic             px_hsync,
    input  logic             px_vsync,
    input  logic             px_blank,
    input  logic [7:0]       px_red,
    input  logic [7:0]       px_green,
    input  logic [7:0]       px_blue,
    output logic [LANES-1:0] LVDS_Data,
    output logic             LVDS_Clock,
    output logic             underflow,
    output logic [15:0]      underflow_cnt
);

    generate
        if (LANES != 3 && LANES != 4) begin : g_bad_lanes
            $error("lvds_tx_serializer: LANES must be 3 or 4");
        end
    endgenerate

    function automatic logic [6:0] map_lane(
        input int         lane,
        input logic       jeida,
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b,
        input logic       hs,
        input logic       vs,
        input logic       bl
    );
        logic [6:0] w;
        w = '0;
        if (jeida) begin
            case (lane)
                0:       w = {g[2], r[7:2]};
                1:       w = {b[3:2], g[7:3]};
                2:       w = {bl, vs, hs, b[7:4]};
                default: w = {1'b0, b[1:0], g[1:0], r[1:0]};
            endcase
        end else begin
            case (lane)
                0:       w = {g[0], r[5:0]};
                1:       w = {b[1:0], g[5:1]};
                2:       w = {bl, vs, hs, b[5:2]};
                default: w = {1'b0, b[7:6], g[7:6], r[7:6]};
            endcase
        end
        return w;
    endfunction

    // Move the next bit to send into the output position, zero-filling behind it.
    function automatic logic [6:0] shift_word(input logic [6:0] w);
        return MSB_FIRST ? {w[5:0], 1'b0} : {1'b0, w[6:1]};
    endfunction

    function automatic logic out_bit(input logic [6:0] w);
        return MSB_FIRST ? w[6] : w[0];
    endfunction

    logic [2:0] phase;
    logic       boundary;
    logic       transfer;
    logic       jeida;
    logic       armed;
    logic       test_mode;
    logic [6:0] lane_sr    [LANES];
    logic [6:0] last_word  [LANES];
    logic [6:0] pixel_word [LANES];
    logic [6:0] clk_sr;

    // 18 bpp links always use the JEIDA packing for lanes 0..2.
    assign jeida    = (LANES == 3) ? 1'b1 : color_mode;
    assign boundary = (phase == 3'd6);
    assign px_ready = boundary && !reset && !test_mode;
    assign transfer = px_valid && px_ready;

    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            pixel_word[n] = map_lane(n, jeida, px_red, px_green, px_blue,
                                     px_hsync, px_vsync, px_blank);
        end
    end

`ifdef LVDS_TX_PRBS_EN
    // PRBS7 x^7+x^6+1; seven steps per frame, oldest new bit sent first.
    function automatic logic [6:0] prbs_step7(input logic [6:0] s);
        logic [6:0] t;
        t = s;
        for (int k = 0; k < 7; k++) begin
            t = {t[5:0], t[6] ^ t[5]};
        end
        return t;
    endfunction

    function automatic logic [6:0] bit_reverse(input logic [6:0] w);
        logic [6:0] r;
        r = '0;
        for (int k = 0; k < 7; k++) begin
            r[k] = w[6-k];
        end
        return r;
    endfunction

    logic [6:0] lfsr      [LANES];
    logic [6:0] lfsr_next [LANES];
    logic [6:0] prbs_word [LANES];

    assign test_mode = prbs_en;

    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            lfsr_next[n] = prbs_step7(lfsr[n]);
            prbs_word[n] = MSB_FIRST ? lfsr_next[n] : bit_reverse(lfsr_next[n]);
        end
    end

    always_ff @(posedge Serial_Clock) begin
        if (reset) begin
            for (int n = 0; n < LANES; n++) begin
                lfsr[n] <= 7'h7F ^ 7'(n);
            end
        end else if (boundary && prbs_en) begin
            for (int n = 0; n < LANES; n++) begin
                lfsr[n] <= lfsr_next[n];
            end
        end
    end
`else
    assign test_mode = 1'b0;
`endif

    always_ff @(posedge Serial_Clock) begin
        if (reset) begin
            phase         <= '0;
            armed         <= 1'b0;
            clk_sr        <= '0;
            LVDS_Clock    <= 1'b0;
            LVDS_Data     <= '0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
            for (int n = 0; n < LANES; n++) begin
                lane_sr[n]   <= '0;
                last_word[n] <= '0;
            end
        end else begin
            underflow  <= 1'b0;
            LVDS_Clock <= out_bit(clk_sr);
            for (int n = 0; n < LANES; n++) begin
                LVDS_Data[n] <= out_bit(lane_sr[n]);
            end
            if (boundary) begin
                phase  <= '0;
                armed  <= 1'b1;
                clk_sr <= CLK_PATTERN;
                if (test_mode) begin
`ifdef LVDS_TX_PRBS_EN
                    for (int n = 0; n < LANES; n++) begin
                        lane_sr[n] <= prbs_word[n];
                    end
`endif
                end else if (transfer) begin
                    for (int n = 0; n < LANES; n++) begin
                        lane_sr[n]   <= pixel_word[n];
                        last_word[n] <= pixel_word[n];
                    end
                end else begin
                    for (int n = 0; n < LANES; n++) begin
                        lane_sr[n] <= last_word[n];
                    end
                    // The boundary straight after reset has no source yet and is not an underflow.
                    if (armed) begin
                        underflow <= 1'b1;
                        if (underflow_cnt != 16'hFFFF) begin
                            underflow_cnt <= underflow_cnt + 16'd1;
                        end
                    end
                end
            end else begin
                phase  <= phase + 3'd1;
                clk_sr <= shift_word(clk_sr);
                for (int n = 0; n < LANES; n++) begin
                    lane_sr[n] <= shift_word(lane_sr[n]);
                end
            end
        end
    end

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Bench for lvds_tx_serializer: a 4-lane MSB-first and a 3-lane LSB-first instance share stimulus
// and are compared each cycle with a frame-level reference model.
`timescale 1ns/1ps
module tb_lvds_tx_serializer;
    localparam int MAXF = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        color_mode = 1'b0;
    logic        px_valid = 1'b0;
    logic        hs = 1'b0, vs = 1'b0, bl = 1'b0;
    logic [7:0]  red = '0, green = '0, blue = '0;
    logic        prbs_en = 1'b0;
    logic        ready4, ready3, uf4, uf3, clk4, clk3;
    logic [15:0] cnt4, cnt3;
    logic [3:0]  d4;
    logic [2:0]  d3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lvds_tx_serializer #(.LANES(4), .CLK_PATTERN(7'b1100011), .MSB_FIRST(1'b1)) dut4 (
        .Serial_Clock(clk), .reset(rst), .color_mode(color_mode),
`ifdef LVDS_TX_PRBS_EN
        .prbs_en(prbs_en),
`endif
        .px_valid(px_valid), .px_ready(ready4),
        .px_hsync(hs), .px_vsync(vs), .px_blank(bl),
        .px_red(red), .px_green(green), .px_blue(blue),
        .LVDS_Data(d4), .LVDS_Clock(clk4), .underflow(uf4), .underflow_cnt(cnt4)
    );

    lvds_tx_serializer #(.LANES(3), .CLK_PATTERN(7'b1100011), .MSB_FIRST(1'b0)) dut3 (
        .Serial_Clock(clk), .reset(rst), .color_mode(color_mode),
`ifdef LVDS_TX_PRBS_EN
        .prbs_en(prbs_en),
`endif
        .px_valid(px_valid), .px_ready(ready3),
        .px_hsync(hs), .px_vsync(vs), .px_blank(bl),
        .px_red(red), .px_green(green), .px_blue(blue),
        .LVDS_Data(d3), .LVDS_Clock(clk3), .underflow(uf3), .underflow_cnt(cnt3)
    );

    // Reference model: cycle count since reset release, the word set loaded at each frame boundary.
    int          cyc = 0;
    int          exp_cnt = 0;
    logic [6:0]  w4 [MAXF][4];
    logic [6:0]  w3 [MAXF][3];
    bit          xf [MAXF];
    bit          pr [MAXF];
    logic [6:0]  lw4 [4];
    logic [6:0]  lw3 [3];
    logic [6:0]  ps4 [4];
    logic [6:0]  ps3 [3];
    logic [6:0]  clkp = 7'b1100011;
    logic [3:0]  exp_d4;
    logic [2:0]  exp_d3;
    logic        exp_c4, exp_c3, exp_uf, exp_ready;
    logic [44:0] expv, obsv;

    // Each colour splits into a 6-bit part and a 2-bit part; the 28-bit stream is cut into lanes.
    function automatic logic [6:0] ref_word(input int lane, input logic jeida,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b, input logic h,
                                            input logic v, input logic k);
        logic [5:0]  rh, gh, bh;
        logic [1:0]  rl, gl, bll;
        logic [27:0] s;
        rh  = jeida ? r[7:2] : r[5:0];
        gh  = jeida ? g[7:2] : g[5:0];
        bh  = jeida ? b[7:2] : b[5:0];
        rl  = jeida ? r[1:0] : r[7:6];
        gl  = jeida ? g[1:0] : g[7:6];
        bll = jeida ? b[1:0] : b[7:6];
        s   = {1'b0, bll, gl, rl, k, v, h, bh, gh, rh};
        return s[7*lane +: 7];
    endfunction

    task automatic model_reset();
        cyc = 0;
        exp_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            lw4[n] = '0;
            ps4[n] = 7'h7F ^ 7'(n);
        end
        for (int n = 0; n < 3; n++) begin
            lw3[n] = '0;
            ps3[n] = 7'h7F ^ 7'(n);
        end
    endtask

    task automatic tick();
        int         f, j;
        logic [6:0] st, pw;
        logic       nb;
        if (!rst && (cyc % 7 == 6)) begin
            f = cyc / 7;
            xf[f] = px_valid && !prbs_en;
            pr[f] = prbs_en;
            for (int n = 0; n < 4; n++) begin
                if (prbs_en) begin
                    st = ps4[n];
                    pw = '0;
                    for (int k = 0; k < 7; k++) begin
                        nb = st[6] ^ st[5];
                        st = {st[5:0], nb};
                        pw[6-k] = nb;
                    end
                    ps4[n] = st;
                    w4[f][n] = pw;
                end else begin
                    if (px_valid) lw4[n] = ref_word(n, color_mode, red, green, blue, hs, vs, bl);
                    w4[f][n] = lw4[n];
                end
            end
            for (int n = 0; n < 3; n++) begin
                if (prbs_en) begin
                    st = ps3[n];
                    pw = '0;
                    for (int k = 0; k < 7; k++) begin
                        nb = st[6] ^ st[5];
                        st = {st[5:0], nb};
                        pw[k] = nb;
                    end
                    ps3[n] = st;
                    w3[f][n] = pw;
                end else begin
                    if (px_valid) lw3[n] = ref_word(n, 1'b1, red, green, blue, hs, vs, bl);
                    w3[f][n] = lw3[n];
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else cyc++;
        exp_d4 = '0;
        exp_d3 = '0;
        exp_c4 = 1'b0;
        exp_c3 = 1'b0;
        exp_uf = 1'b0;
        if (cyc >= 8) begin
            f = (cyc - 8) / 7;
            j = (cyc - 8) % 7;
            for (int n = 0; n < 4; n++) exp_d4[n] = w4[f][n][6-j];
            for (int n = 0; n < 3; n++) exp_d3[n] = w3[f][n][j];
            exp_c4 = clkp[6-j];
            exp_c3 = clkp[j];
        end
        if (cyc >= 7 && ((cyc - 7) % 7 == 0)) begin
            f = (cyc - 7) / 7;
            if (f > 0 && !xf[f] && !pr[f]) begin
                exp_uf = 1'b1;
                exp_cnt++;
            end
        end
        exp_ready = (cyc % 7 == 6) && !rst && !prbs_en;
        expv = {exp_ready, exp_ready, exp_uf, exp_uf, 16'(exp_cnt), 16'(exp_cnt),
                exp_c4, exp_c3, exp_d4, exp_d3};
        obsv = {ready4, ready3, uf4, uf3, cnt4, cnt3, clk4, clk3, d4, d3};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        px_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obsv !== 45'd0) begin
                miscompares++;
                $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obsv, 45'd0);
            end
        end
    endtask

    task automatic test_jeida();
        logic [6:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0, sc = '0;
        rst = 1'b0;
        color_mode = 1'b1;
        px_valid = 1'b1;
        red = 8'hFC; green = 8'h04; blue = 8'h00;
        hs = 1'b0; vs = 1'b0; bl = 1'b0;
        for (int i = 0; i < 35; i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL jeida cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
            if (cyc >= 8 && cyc <= 14) begin
                s0 = {s0[5:0], d4[0]};
                s1 = {s1[5:0], d4[1]};
                s2 = {s2[5:0], d4[2]};
                s3 = {s3[5:0], d4[3]};
                sc = {sc[5:0], clk4};
            end
        end
        vectors += 5;
        if (s0 !== 7'b1111111) begin miscompares++; $display("FAIL jeida_l0 got=%b exp=1111111", s0); end
        if (s1 !== 7'b0000000) begin miscompares++; $display("FAIL jeida_l1 got=%b exp=0000000", s1); end
        if (s2 !== 7'b0000000) begin miscompares++; $display("FAIL jeida_l2 got=%b exp=0000000", s2); end
        if (s3 !== 7'b0000000) begin miscompares++; $display("FAIL jeida_l3 got=%b exp=0000000", s3); end
        if (sc !== 7'b1100011) begin miscompares++; $display("FAIL clock_lane got=%b exp=1100011", sc); end
    endtask

    task automatic test_vesa();
        int         t;
        logic [6:0] s0 = '0, s2 = '0, s3 = '0;
        for (int i = 0; i < 7 && (cyc % 7 != 6); i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL vesa_align cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
        end
        t = cyc;
        color_mode = 1'b0;
        red = 8'h3F; green = 8'h00; blue = 8'hC0; bl = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL vesa cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
            if (cyc == t + 1) begin
                vectors++;
                if (d4[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL vesa_latency cyc=%0d got=%b exp=1", cyc, d4[0]);
                end
            end
            if (cyc >= t + 2 && cyc <= t + 8) begin
                s0 = {s0[5:0], d4[0]};
                s2 = {s2[5:0], d4[2]};
                s3 = {s3[5:0], d4[3]};
            end
        end
        vectors += 3;
        if (s0 !== 7'b0111111) begin miscompares++; $display("FAIL vesa_l0 got=%b exp=0111111", s0); end
        if (s2 !== 7'b1000000) begin miscompares++; $display("FAIL vesa_l2 got=%b exp=1000000", s2); end
        if (s3 !== 7'b0110000) begin miscompares++; $display("FAIL vesa_l3 got=%b exp=0110000", s3); end
    endtask

    task automatic test_underflow();
        int pulses = 0;
        for (int i = 0; i < 7 && (cyc % 7 != 6); i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL uf_align cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
        end
        red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
        px_valid = 1'b1;
        tick();
        vectors++;
        if (obsv !== expv) begin
            miscompares++;
            $display("FAIL uf_load cyc=%0d got=%h exp=%h", cyc, obsv, expv);
        end
        px_valid = 1'b0;
        for (int i = 0; i < 21; i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL underflow cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
            if (uf4) pulses++;
        end
        px_valid = 1'b1;
        vectors += 2;
        if (pulses != 3) begin miscompares++; $display("FAIL uf_pulses got=%0d exp=3", pulses); end
        if (cnt4 !== 16'd3) begin miscompares++; $display("FAIL uf_count got=%0d exp=3", cnt4); end
    endtask

    task automatic test_lanes3();
        int         t;
        logic [6:0] v = '0;
        for (int i = 0; i < 7 && (cyc % 7 != 6); i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL l3_align cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
        end
        t = cyc;
        color_mode = 1'b0;
        red = 8'h04; green = 8'h00; blue = 8'h00;
        hs = 1'b0; vs = 1'b0; bl = 1'b0;
        px_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL lanes3 cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
            if (cyc >= t + 2 && cyc <= t + 8) v = {v[5:0], d3[0]};
            color_mode = ~color_mode;
        end
        vectors++;
        if (v !== 7'b1000000) begin miscompares++; $display("FAIL lanes3_l0 got=%b exp=1000000", v); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 280; i++) begin
            px_valid = ($urandom_range(0, 9) < 7);
            color_mode = 1'($urandom);
            red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
            hs = 1'($urandom); vs = 1'($urandom); bl = 1'($urandom);
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit got = 0;
        for (int i = 0; i < 7 && (cyc % 7 != 3); i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL rmid_align cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (obsv !== 45'd0) begin
            miscompares++;
            $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, obsv, 45'd0);
        end
        rst = 1'b0;
        px_valid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            n++;
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL rmid_run cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
            if (ready4) got = 1;
        end
        vectors += 2;
        if (!got || n != 6) begin miscompares++; $display("FAIL ready_after_reset got=%0d exp=6", n); end
        if (cnt4 !== 16'd0) begin miscompares++; $display("FAIL rmid_count got=%0d exp=0", cnt4); end
        for (int i = 0; i < 28; i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL rmid_idle cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
        end
    endtask

`ifdef LVDS_TX_PRBS_EN
    task automatic test_prbs();
        int         t;
        logic [6:0] v = '0, e = '0, st = 7'h7F;
        logic       nb;
        for (int i = 0; i < 7 && (cyc % 7 != 6); i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL prbs_align cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
        end
        t = cyc;
        prbs_en = 1'b1;
        px_valid = 1'b1;
        for (int i = 0; i < 21; i++) begin
            tick();
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL prbs cyc=%0d got=%h exp=%h", cyc, obsv, expv);
            end
            if (cyc >= t + 2 && cyc <= t + 8) v = {v[5:0], d4[0]};
        end
        prbs_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            nb = st[6] ^ st[5];
            st = {st[5:0], nb};
            e = {e[5:0], nb};
        end
        vectors++;
        if (v !== e) begin miscompares++; $display("FAIL prbs_l0 got=%b exp=%b", v, e); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_jeida();
        test_vesa();
        test_underflow();
        test_lanes3();
        test_random();
        test_reset_mid();
`ifdef LVDS_TX_PRBS_EN
        test_prbs();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
